// File: rtl/shift_reg_univ.sv
// Universal shift register: shifts, rotates, parallel load, and an LSB-first
// serializer that drives so_r for WIDTH cycles once started.
module shift_reg_univ #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [2:0]                     op,
    input  logic                           si_r,
    input  logic                           si_l,
    input  logic [WIDTH-1:0]               d,
    output logic [WIDTH-1:0]               q,
    output logic                           so_r,
    output logic                           so_l,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(WIDTH+1)-1:0]     cnt
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    typedef logic [CntW-1:0] cnt_t;

    typedef enum logic {StIdle, StSer} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    cnt_t              cnt_q, cnt_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        // done is a one-cycle pulse and clears even while en is low
        done_d  = 1'b0;
        if (en) begin
            unique case (state_q)
                StIdle: begin
                    unique case (op)
                        3'b000: shreg_d = shreg_q;
                        3'b001: shreg_d = {si_r, shreg_q[WIDTH-1:1]};
                        3'b010: shreg_d = {shreg_q[WIDTH-2:0], si_l};
                        3'b011: shreg_d = {shreg_q[0], shreg_q[WIDTH-1:1]};
                        3'b100: shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
                        3'b101: shreg_d = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
                        3'b110: shreg_d = d;
                        3'b111: begin
                            shreg_d = d;
                            cnt_d   = cnt_t'(WIDTH);
                            state_d = StSer;
                        end
                    endcase
                end
                StSer: begin
                    // op is ignored here; a start request while busy is dropped
                    shreg_d = {si_r, shreg_q[WIDTH-1:1]};
                    cnt_d   = cnt_q - cnt_t'(1);
                    if (cnt_q == cnt_t'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign q    = shreg_q;
    assign so_r = shreg_q[0];
    assign so_l = shreg_q[WIDTH-1];
    assign busy = (state_q == StSer);
    assign done = done_q;
    assign cnt  = cnt_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ (WIDTH=8): directed scenarios plus random stimulus,
// all outputs compared against an arithmetic reference model every cycle.
module tb_shift_reg_univ;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n, en, si_r, si_l;
    logic [2:0]   op;
    logic [W-1:0] d, q;
    logic         so_r, so_l, busy, done;
    logic [3:0]   cnt;

    shift_reg_univ #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .op   (op),
        .si_r (si_r),
        .si_l (si_l),
        .d    (d),
        .q    (q),
        .so_r (so_r),
        .so_l (so_l),
        .busy (busy),
        .done (done),
        .cnt  (cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: register value as a number, plus serializer bookkeeping
    int mq, mcnt;
    bit mbusy, mdone;

    int           nb, nd, bi;
    logic [7:0]   sv, snap_q;
    logic [3:0]   snap_cnt;
    logic         snap_so;
    bit           e;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq = 0; mcnt = 0; mbusy = 0; mdone = 0;
    endtask

    // Next state from the current inputs, computed with plain arithmetic
    task automatic model_edge();
        int v;
        v = mq;
        mdone = 0;
        if (en) begin
            if (mbusy) begin
                v = v / 2 + int'(si_r) * 128;
                mcnt--;
                if (mcnt == 0) begin
                    mbusy = 0;
                    mdone = 1;
                end
            end else begin
                case (op)
                    3'd1: v = v / 2 + int'(si_r) * 128;
                    3'd2: v = (v * 2) % 256 + int'(si_l);
                    3'd3: v = v / 2 + (v % 2) * 128;
                    3'd4: v = (v * 2) % 256 + v / 128;
                    3'd5: v = v / 2 + (v / 128) * 128;
                    3'd6: v = int'(d);
                    3'd7: begin v = int'(d); mbusy = 1; mcnt = W; end
                    default: ;
                endcase
            end
        end
        mq = v;
    endtask

    task automatic check_all();
        check("q",    64'(q),    64'(mq));
        check("busy", 64'(busy), 64'(mbusy));
        check("done", 64'(done), 64'(mdone));
        check("cnt",  64'(cnt),  64'(mcnt));
        check("so_r", 64'(so_r), 64'(mq % 2));
        check("so_l", 64'(so_l), 64'(mq / 128));
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic step(input bit ee, input bit [2:0] o, input bit sr, input bit sl,
                        input bit [7:0] dd);
        en = ee; op = o; si_r = sr; si_l = sl; d = dd;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; op = 3'd0; si_r = 1'b0; si_l = 1'b0; d = '0;
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Load and rotations
        step(1, 3'd6, 0, 0, 8'hB4); check("load_b4", 64'(q), 64'hB4);
        step(1, 3'd3, 0, 0, 8'h00);
        step(1, 3'd3, 0, 0, 8'h00); check("rotr2", 64'(q), 64'h2D);
        step(1, 3'd4, 0, 0, 8'h00);
        step(1, 3'd4, 0, 0, 8'h00); check("rotl2", 64'(q), 64'hB4);

        // Arithmetic and logical shifts
        step(1, 3'd6, 0, 0, 8'h96);
        step(1, 3'd5, 0, 0, 8'h00); check("asr", 64'(q), 64'hCB);
        step(1, 3'd1, 0, 0, 8'h00); check("shr", 64'(q), 64'h65);
        step(1, 3'd2, 0, 1, 8'h00); check("shl", 64'(q), 64'hCB);

        // Plain serialization of 0xA5
        step(1, 3'd7, 0, 0, 8'hA5);
        nb = 0; nd = 0; sv = '0;
        for (int i = 0; i < 11; i++) begin
            if (busy && nb < 8) begin
                check("ser_cnt", 64'(cnt), 64'(8 - nb));
                sv[nb] = so_r;
                nb++;
            end
            if (done) nd++;
            step(1, 3'd0, 0, 0, 8'h00);
        end
        check("ser_busy_len", 64'(nb), 64'd8);
        check("ser_done_cnt", 64'(nd), 64'd1);
        check("ser_bits", 64'(sv), 64'hA5);
        check("ser_final_q", 64'(q), 64'h00);

        // Serialization with a 3-cycle enable gap after the 4th shift
        step(1, 3'd7, 0, 0, 8'hA5);
        nb = 1; bi = 1; sv = '0; sv[0] = so_r;
        snap_q = '0; snap_cnt = '0; snap_so = 1'b0;
        for (int i = 0; i < 14; i++) begin
            e = !(i >= 4 && i < 7);
            step(e, 3'd0, 0, 0, 8'h00);
            if (busy) nb++;
            if (e && busy && bi < 8) begin
                sv[bi] = so_r;
                bi++;
            end
            if (i == 3) begin
                snap_q = q; snap_cnt = cnt; snap_so = so_r;
            end
            if (!e) begin
                check("frz_q",   64'(q),    64'(snap_q));
                check("frz_cnt", 64'(cnt),  64'(snap_cnt));
                check("frz_so",  64'(so_r), 64'(snap_so));
            end
        end
        check("gap_busy_len", 64'(nb), 64'd11);
        check("gap_bits", 64'(sv), 64'hA5);

        // Start held through SER restarts only once busy drops; load ignored while busy
        step(1, 3'd7, 0, 0, 8'hA5);
        for (int i = 0; i < 8; i++) step(1, 3'd7, 0, 0, 8'h3C);
        check("hold_idle", 64'(busy), 64'd0);
        check("hold_done", 64'(done), 64'd1);
        step(1, 3'd7, 0, 0, 8'h3C);
        check("restart_q", 64'(q), 64'h3C);
        check("restart_cnt", 64'(cnt), 64'd8);
        step(1, 3'd6, 0, 0, 8'hFF); check("load_ignored", 64'(q), 64'h1E);

        // Asynchronous reset mid-serialization at cnt=5
        step(1, 3'd0, 0, 0, 8'h00);
        step(1, 3'd0, 0, 0, 8'h00);
        check("pre_rst_cnt", 64'(cnt), 64'd5);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_q", 64'(q), 64'h00);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cnt", 64'(cnt), 64'd0);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 3'd0, 0, 0, 8'h00);
            if (done) nd++;
        end
        check("rst_no_done", 64'(nd), 64'd0);
        step(1, 3'd6, 0, 0, 8'h5A); check("post_rst_load", 64'(q), 64'h5A);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
